key_press_conditioner: RTL



---
 rtl/key_cond_pkg.sv | 16 +
 rtl/key_debounce.sv | 54 +++++
 rtl/key_press_conditioner.sv | 125 ++++++++++++
 3 files changed

// File: rtl/key_cond_pkg.sv
// Shared types and constants for the pushbutton conditioner.
// Bit positions match the game engine's KeyLeft/KeyUp/KeyDown/KeyRight inputs.
package key_cond_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } key_state_t;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_UP    = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_RIGHT = 3;

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser on the raw active-low button, then a
// stability counter that only lets a level change through after it holds.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic srst,
  input  logic key_raw_n,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed;

  assign pressed = ~sync2_q;

  always_comb begin
    sync1_d = key_raw_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (pressed != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = pressed;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser resets to the released (high) level.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/key_press_conditioner.sv
// Debounced pushbuttons to single-cycle press/auto-repeat events, with a
// lowest-index-first arbiter so at most one event is emitted per cycle.
module key_press_conditioner
  import key_cond_pkg::*;
#(
  parameter int NUM_KEYS            = 4,
  parameter int DEBOUNCE_CYCLES     = 1000000,
  parameter int REPEAT_DELAY_CYCLES = 25000000,
  parameter int REPEAT_RATE_CYCLES  = 10000000
) (
  input  logic                clock,
  input  logic                globalReset,
  input  logic [NUM_KEYS-1:0] keysRaw_n,
  input  logic                repeatEnable,
  output logic [NUM_KEYS-1:0] keyPulse,
  output logic [NUM_KEYS-1:0] keyHeld
);

  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYCLES - 1);

  logic [NUM_KEYS-1:0] deb_level;
  logic [NUM_KEYS-1:0] request;
  logic [NUM_KEYS-1:0] grant;
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [NUM_KEYS-1:0] pulse_q, pulse_d;
  logic [NUM_KEYS-1:0] held_pipe_q, held_pipe_d;
  logic [NUM_KEYS-1:0] held_q, held_d;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_state_t    state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic          req;

    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clock),
      .srst     (globalReset),
      .key_raw_n(keysRaw_n[gi]),
      .level    (deb_level[gi])
    );

    // Release wins over everything; IDLE only sees level=1 right after a rise.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req     = 1'b0;
      if (!deb_level[gi]) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            req     = 1'b1;
            state_d = DELAY;
            cnt_d   = '0;
          end
          DELAY: begin
            if (cnt_q == DELAY_LAST) begin
              if (repeatEnable) begin
                req     = 1'b1;
                state_d = REPEAT;
                cnt_d   = '0;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          REPEAT: begin
            if (cnt_q == RATE_LAST) begin
              req   = repeatEnable;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    always_ff @(posedge clock) begin
      if (globalReset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign request[gi] = req;
  end

  // Lowest set bit of pending wins; a request landing on a set bit merges.
  always_comb begin
    grant       = pending_q & (~pending_q + 1'b1);
    pending_d   = (pending_q & ~grant) | request;
    pulse_d     = grant;
    held_pipe_d = deb_level;
    held_d      = held_pipe_q;
  end

  always_ff @(posedge clock) begin
    if (globalReset) begin
      pending_q   <= '0;
      pulse_q     <= '0;
      held_pipe_q <= '0;
      held_q      <= '0;
    end else begin
      pending_q   <= pending_d;
      pulse_q     <= pulse_d;
      held_pipe_q <= held_pipe_d;
      held_q      <= held_d;
    end
  end

  assign keyPulse = pulse_q;
  assign keyHeld  = held_q;

endmodule
